window_buffer_ctrl: RTL
=======================

Name: window_buffer_ctrl

Overview:
- Sequences the two cascaded line FIFOs of the 3x3 window buffer. Line 0 FIFO delays the incoming pixel stream by one row; line 1 FIFO delays line 0 output by a further row.
- Tracks column and row position, generates FIFO read/write strobes, window-shift and window-valid qualifiers, and drains both FIFOs at end of frame.
- Sits between the pixel source and the window buffer datapath.

Parameters:
- IMG_WIDTH, 640, pixels per row; the line FIFOs are built with FIFO_DEPTH = IMG_WIDTH; legal values are 3 and above.
- IMG_HEIGHT, 480, rows per frame; legal values are 3 and above.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  start pulse; honoured only in IDLE.
- i_pixel_valid  in  1  a new pixel is present on the datapath input this cycle.
- i_fifo0_full, i_fifo0_empty  in  1 each  line 0 FIFO status.
- i_fifo1_full, i_fifo1_empty  in  1 each  line 1 FIFO status.
- o_fifo0_write, o_fifo0_read  out  1 each  line 0 FIFO strobes.
- o_fifo1_write, o_fifo1_read  out  1 each  line 1 FIFO strobes.
- o_shift  out  1  window registers shift one column this cycle.
- o_window_valid  out  1  window holds a complete 3x3 neighbourhood.
- o_col  out  $clog2(IMG_WIDTH)  column of the pixel accepted next.
- o_row  out  $clog2(IMG_HEIGHT)  row of the pixel accepted next.
- o_busy  out  1  state is not IDLE.
- o_frame_done  out  1  single-cycle pulse when the drain completes.
- o_error  out  1  sticky overflow flag.

Behaviour:
- Clock and reset: single clock i_clk; reset i_reset_n is asynchronous, active-low.
- Reset values: state IDLE; all counters 0; every output 0.
- States: IDLE, STREAM, FLUSH.
- IDLE -> STREAM on i_frame_start. On the same edge, o_col and o_row are cleared to 0 and o_error is cleared.
- STREAM: accept = i_pixel_valid. o_shift = accept (combinational).
- STREAM FIFO strobes (all combinational):
  - o_fifo0_write = accept.
  - o_fifo0_read = accept && row >= 1.
  - o_fifo1_write = o_fifo0_read.
  - o_fifo1_read = accept && row >= 2.
- Counters: on accept, col increments. At col = IMG_WIDTH-1, col wraps to 0 and row increments.
- Steady-state occupancy: each line FIFO holds exactly IMG_WIDTH entries once primed.
- o_window_valid is registered. It is 1 in the cycle after an accept whose (row, col) has row >= 2 and col >= 2, and 0 otherwise (including after non-accept cycles).
- STREAM -> FLUSH on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1). Counters return to 0.
- FLUSH: o_fifo0_read = !i_fifo0_empty and o_fifo1_read = !i_fifo1_empty. No writes; o_shift = 0; i_pixel_valid is ignored.
- FLUSH -> IDLE in the first cycle both empty flags are 1. o_frame_done pulses high for 1 cycle, registered on that transition.
- i_frame_start outside IDLE is ignored. i_pixel_valid in IDLE is ignored: no strobes, no counting.
- Overflow: an asserted o_fifo0_write with i_fifo0_full = 1, or o_fifo1_write with i_fifo1_full = 1, sets o_error on the next edge. o_error holds until the next accepted i_frame_start or reset. The strobe is still issued; the FIFO discards the write.
- Reset mid-frame: immediate return to IDLE with reset values. The FIFOs are reset by the same i_reset_n.
- o_busy = (state != IDLE), combinational from the state register.

Optional Feature:
- Macro: WINDOW_BUF_CTRL_STATS_EN.
- Defined: adds output o_frame_count (16 bits), reset 0, incremented on each o_frame_done, wrapping at 0xFFFF -> 0. Also adds output o_stall_cycles (16 bits, saturating at 0xFFFF), counting STREAM cycles with i_pixel_valid = 0 in the current frame and cleared on frame start.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset/idle, IMG_WIDTH=4, IMG_HEIGHT=3: hold reset, release, pulse i_pixel_valid -> all strobes 0, o_busy=0, o_col=o_row=0.
- Full frame, continuous valid, W=4, H=3: o_fifo0_read first at pixel 4; o_fifo1_read first at pixel 8. o_window_valid high in the cycles after pixels 10 and 11 only. FLUSH reads 4 entries per FIFO, then o_frame_done pulses once.
- Gapped valid (valid every other cycle), same frame: identical strobe and valid sequence per accepted pixel; o_window_valid never high after an idle cycle.
- i_frame_start pulsed during STREAM and FLUSH -> no effect on counters or state. A second frame started after o_frame_done completes normally.
- i_fifo0_full forced to 1 during a write -> o_error=1 next cycle, stays 1 through FLUSH, cleared by the next i_frame_start.
- i_reset_n asserted at row 1, col 2 -> outputs zero asynchronously, state IDLE. With WINDOW_BUF_CTRL_STATS_EN defined, two frames -> o_frame_count=2.

Source files
------------

// File: rtl/window_buffer_ctrl.sv
// window_buffer_ctrl
// Sequences the two cascaded line FIFOs that feed a 3x3 window buffer.
// Line 0 delays the pixel stream by one row and line 1 delays line 0 by a
// further row. The block tracks the column/row position, issues FIFO
// strobes plus window shift/valid qualifiers, and drains both FIFOs once
// the last pixel of a frame is accepted.
//
// Optional build macro WINDOW_BUF_CTRL_STATS_EN adds a wrapping frame
// counter (o_frame_count) and a saturating per-frame stall counter
// (o_stall_cycles). With the macro undefined those ports do not exist.
module window_buffer_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_frame_start,
  input  logic                          i_pixel_valid,
  input  logic                          i_fifo0_full,
  input  logic                          i_fifo0_empty,
  input  logic                          i_fifo1_full,
  input  logic                          i_fifo1_empty,
  output logic                          o_fifo0_write,
  output logic                          o_fifo0_read,
  output logic                          o_fifo1_write,
  output logic                          o_fifo1_read,
  output logic                          o_shift,
  output logic                          o_window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
  output logic                          o_busy,
  output logic                          o_frame_done,
`ifdef WINDOW_BUF_CTRL_STATS_EN
  output logic [15:0]                   o_frame_count,
  output logic [15:0]                   o_stall_cycles,
`endif
  output logic                          o_error
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          error_q, error_d;
  logic          window_valid_q, window_valid_d;
  logic          frame_done_q, frame_done_d;

  logic          accept_s;
  logic          fifo0_write_s;
  logic          fifo0_read_s;
  logic          fifo1_write_s;
  logic          fifo1_read_s;

  // Next-state, counter and strobe decode for the three-state sequencer.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    error_d        = error_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    accept_s       = 1'b0;
    fifo0_write_s  = 1'b0;
    fifo0_read_s   = 1'b0;
    fifo1_write_s  = 1'b0;
    fifo1_read_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Pixels arriving while idle are ignored; only a start pulse matters.
        if (i_frame_start) begin
          state_d = S_STREAM;
          col_d   = '0;
          row_d   = '0;
          error_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_STREAM: begin
        accept_s      = i_pixel_valid;
        fifo0_write_s = accept_s;
        // Line 0 starts emitting once a full row is stored in it.
        fifo0_read_s  = accept_s && (row_q >= RW'(1));
        fifo1_write_s = fifo0_read_s;
        fifo1_read_s  = accept_s && (row_q >= RW'(2));
        // Three rows and three columns seen => full neighbourhood next cycle.
        window_valid_d = accept_s && (row_q >= RW'(2)) && (col_q >= CW'(2));

        if (accept_s) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          col_d = col_q;
        end
      end

      S_FLUSH: begin
        // Drain whatever is left in each line FIFO; new pixels are ignored.
        fifo0_read_s = !i_fifo0_empty;
        fifo1_read_s = !i_fifo1_empty;
        if (i_fifo0_empty && i_fifo1_empty) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end

      default: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase

    // Writing into a full FIFO loses data: latch the condition until restart.
    if ((fifo0_write_s && i_fifo0_full) || (fifo1_write_s && i_fifo1_full)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_d;
    end
  end

  // State, position counters and registered qualifiers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      error_q        <= 1'b0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      error_q        <= error_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

`ifdef WINDOW_BUF_CTRL_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Statistics next-state: wrapping frame count, saturating stall count.
  always_comb begin
    frame_count_d  = frame_count_q;
    stall_cycles_d = stall_cycles_q;
    if (frame_done_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
    if ((state_q == S_IDLE) && i_frame_start) begin
      stall_cycles_d = 16'd0;
    end else if ((state_q == S_STREAM) && !i_pixel_valid &&
                 (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_count_q  <= 16'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      frame_count_q  <= frame_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_frame_count  = frame_count_q;
  assign o_stall_cycles = stall_cycles_q;
`endif

  assign o_fifo0_write  = fifo0_write_s;
  assign o_fifo0_read   = fifo0_read_s;
  assign o_fifo1_write  = fifo1_write_s;
  assign o_fifo1_read   = fifo1_read_s;
  assign o_shift        = accept_s;
  assign o_window_valid = window_valid_q;
  assign o_col          = col_q;
  assign o_row          = row_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_frame_done   = frame_done_q;
  assign o_error        = error_q;

endmodule
